// File: rtl/pipeline_interlock_unit.sv
// Hazard interlock for the LEGv8 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory freeze with a sticky timeout, plus saturating counters.
module pipeline_interlock_unit #(
    parameter int MAX_MEM_WAIT = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IDEX_MemRead,
    input  logic [4:0]           IDEX_RegisterRd,
    input  logic [4:0]           IFID_RegisterRn,
    input  logic [4:0]           IFID_RegisterRm,
    input  logic                 IFID_UsesRm,
    input  logic                 MEM_BranchTaken,
    input  logic                 DMEM_Busy,
    output logic                 PCWrite,
    output logic                 IFID_Write,
    output logic                 IDEX_Bubble,
    output logic                 IFID_Flush,
    output logic                 IDEX_Flush,
    output logic                 EXMEM_Flush,
    output logic                 Pipe_Freeze,
    output logic                 Timeout,
    output logic [CNT_WIDTH-1:0] Stall_Count,
    output logic [CNT_WIDTH-1:0] Flush_Count
);

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_pending_flush;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic                 r_timeout;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_flush;
    logic w_stall;

    // XZR is never a real destination, so a load into X31 cannot create a hazard.
    assign w_load_use = IDEX_MemRead && (IDEX_RegisterRd != 5'd31) &&
                        ((IDEX_RegisterRd == IFID_RegisterRn) ||
                         (IFID_UsesRm && (IDEX_RegisterRd == IFID_RegisterRm)));
    assign w_flush    = !DMEM_Busy && (MEM_BranchTaken || r_pending_flush);
    assign w_stall    = !DMEM_Busy && !w_flush && w_load_use;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) r_state <= RUN;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (DMEM_Busy)  w_next_state = MEM_WAIT;
            MEM_WAIT: if (!DMEM_Busy) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // and infers a latch.
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Pipe_Freeze = 1'b0;
        if (reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (DMEM_Busy) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (w_flush) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (w_stall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending_flush <= 1'b0;
            r_wait_cnt      <= '0;
            r_timeout       <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (DMEM_Busy) begin
                // A branch resolved while frozen must still flush once memory releases.
                if (MEM_BranchTaken) r_pending_flush <= 1'b1;
                if (r_wait_cnt != WAIT_W'(MAX_MEM_WAIT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                if (r_wait_cnt == WAIT_W'(MAX_MEM_WAIT - 1)) r_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_flush) begin
                r_pending_flush <= 1'b0;
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign Timeout     = r_timeout;
    assign Stall_Count = r_stall_cnt;
    assign Flush_Count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_interlock_unit.sv
// Randomized and directed bench for pipeline_interlock_unit: two instances (small and
// default parameters) share stimulus and are compared against a behavioural model.
module tb_pipeline_interlock_unit;

    localparam int A_WAIT = 4;
    localparam int A_CW   = 2;
    localparam int B_WAIT = 64;
    localparam int B_CW   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_RegisterRd;
    logic [4:0] IFID_RegisterRn;
    logic [4:0] IFID_RegisterRm;
    logic       IFID_UsesRm;
    logic       MEM_BranchTaken;
    logic       DMEM_Busy;

    logic a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz, a_tout;
    logic b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz, b_tout;
    logic [A_CW-1:0] a_stall, a_flush;
    logic [B_CW-1:0] b_stall, b_flush;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: counts are unbounded and clipped on comparison.
    bit m_pending;
    int m_busy_run;
    int m_stalls;
    int m_flushes;
    bit m_tout_a;
    bit m_tout_b;

    always #5 clk = ~clk;

    pipeline_interlock_unit #(.MAX_MEM_WAIT(A_WAIT), .CNT_WIDTH(A_CW)) u_dut_a (
        .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
        .IFID_RegisterRn(IFID_RegisterRn), .IFID_RegisterRm(IFID_RegisterRm), .IFID_UsesRm(IFID_UsesRm),
        .MEM_BranchTaken(MEM_BranchTaken), .DMEM_Busy(DMEM_Busy),
        .PCWrite(a_pcw), .IFID_Write(a_ifw), .IDEX_Bubble(a_bub), .IFID_Flush(a_iff),
        .IDEX_Flush(a_idf), .EXMEM_Flush(a_exf), .Pipe_Freeze(a_frz), .Timeout(a_tout),
        .Stall_Count(a_stall), .Flush_Count(a_flush)
    );

    pipeline_interlock_unit #(.MAX_MEM_WAIT(B_WAIT), .CNT_WIDTH(B_CW)) u_dut_b (
        .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
        .IFID_RegisterRn(IFID_RegisterRn), .IFID_RegisterRm(IFID_RegisterRm), .IFID_UsesRm(IFID_UsesRm),
        .MEM_BranchTaken(MEM_BranchTaken), .DMEM_Busy(DMEM_Busy),
        .PCWrite(b_pcw), .IFID_Write(b_ifw), .IDEX_Bubble(b_bub), .IFID_Flush(b_iff),
        .IDEX_Flush(b_idf), .EXMEM_Flush(b_exf), .Pipe_Freeze(b_frz), .Timeout(b_tout),
        .Stall_Count(b_stall), .Flush_Count(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int width);
        int lim;
        lim = (1 << width) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // One clock: drive inputs at the falling edge, check the combinational controls,
    // advance the model across the rising edge, then check registered outputs.
    task automatic cycle(input string tag, input bit rst, input bit busy, input bit br,
                         input bit mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input bit um);
        bit hazard;
        bit do_flush;
        logic [6:0] exp_ctl;
        @(negedge clk);
        reset = rst; DMEM_Busy = busy; MEM_BranchTaken = br; IDEX_MemRead = mr;
        IDEX_RegisterRd = rd; IFID_RegisterRn = rn; IFID_RegisterRm = rm; IFID_UsesRm = um;
        #1;
        hazard   = mr && rd != 5'd31 && (rd == rn || (um && rd == rm));
        do_flush = !busy && (br || m_pending);
        // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Freeze}
        if (rst)           exp_ctl = 7'b0001110;
        else if (busy)     exp_ctl = 7'b0000001;
        else if (do_flush) exp_ctl = 7'b1101110;
        else if (hazard)   exp_ctl = 7'b0010000;
        else               exp_ctl = 7'b1100000;
        check({tag, ".ctl_a"}, 32'({a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_frz}), 32'(exp_ctl));
        check({tag, ".ctl_b"}, 32'({b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_frz}), 32'(exp_ctl));
        @(posedge clk);
        if (rst) begin
            m_pending = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0;
            m_tout_a = 0; m_tout_b = 0;
        end else begin
            if (busy) begin
                m_busy_run++;
                if (br) m_pending = 1;
                if (m_busy_run >= A_WAIT) m_tout_a = 1;
                if (m_busy_run >= B_WAIT) m_tout_b = 1;
            end else begin
                m_busy_run = 0;
                if (do_flush) begin
                    m_pending = 0;
                    m_flushes++;
                end else if (hazard) begin
                    m_stalls++;
                end
            end
        end
        #1;
        check({tag, ".stall_a"}, 32'(a_stall), 32'(clip(m_stalls, A_CW)));
        check({tag, ".flush_a"}, 32'(a_flush), 32'(clip(m_flushes, A_CW)));
        check({tag, ".stall_b"}, 32'(b_stall), 32'(clip(m_stalls, B_CW)));
        check({tag, ".flush_b"}, 32'(b_flush), 32'(clip(m_flushes, B_CW)));
        check({tag, ".tout_a"},  32'(a_tout),  32'(m_tout_a));
        check({tag, ".tout_b"},  32'(b_tout),  32'(m_tout_b));
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    endtask

    task automatic do_reset();
        cycle("reset", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        reset = 1'b1; DMEM_Busy = 0; MEM_BranchTaken = 0; IDEX_MemRead = 0;
        IDEX_RegisterRd = 0; IFID_RegisterRn = 0; IFID_RegisterRm = 0; IFID_UsesRm = 0;
        m_pending = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0; m_tout_a = 0; m_tout_b = 0;

        do_reset();

        // Load-use on Rn: single stall cycle, then normal flow.
        cycle("lu_rn", 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        idle("lu_rn_after");
        check("lu_rn.count", 32'(b_stall), 32'd1);

        // Rm only counts when used; XZR never stalls.
        cycle("rm_unused", 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
        cycle("rm_used",   0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
        cycle("xzr",       0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1);

        // Branch beats a simultaneous load-use hazard.
        do_reset();
        cycle("br_hazard", 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        check("br_hazard.fc", 32'(b_flush), 32'd1);
        check("br_hazard.sc", 32'(b_stall), 32'd0);

        // Branch resolved during a freeze is flushed once memory releases.
        do_reset();
        cycle("busy_br1", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
        cycle("busy_br2", 0, 1, 0, 1, 5'd3, 5'd3, 5'd2, 0);
        cycle("busy_br3", 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        cycle("busy_rel", 0, 0, 0, 1, 5'd3, 5'd3, 5'd2, 0);
        check("busy_rel.fc", 32'(b_flush), 32'd1);
        idle("busy_after");

        // Timeout on the small instance after the fourth busy edge, sticky until reset.
        do_reset();
        for (int i = 0; i < 6; i++) cycle("tout_busy", 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        idle("tout_rel");
        check("tout_sticky", 32'(a_tout), 32'd1);
        do_reset();
        check("tout_cleared", 32'(a_tout), 32'd0);

        // Counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            cycle("sat_stall", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0);
            idle("sat_gap");
        end
        check("sat.stall_a", 32'(a_stall), 32'd3);
        check("sat.stall_b", 32'(b_stall), 32'd5);

        // Long freeze reaches the default-parameter timeout.
        do_reset();
        for (int i = 0; i < 66; i++) cycle("long_busy", 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
        idle("long_rel");

        // Randomized traffic with occasional resets and freeze bursts.
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_busy, r_br, r_mr, r_um;
            logic [4:0] r_rd, r_rn, r_rm;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_busy = ($urandom_range(0, 3) == 0);
            r_br   = ($urandom_range(0, 5) == 0);
            r_mr   = ($urandom_range(0, 1) == 1);
            r_um   = ($urandom_range(0, 1) == 1);
            r_rd   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            r_rn   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            r_rm   = 5'($urandom_range(0, 3));
            cycle("rand", r_rst, r_busy, r_br, r_mr, r_rd, r_rn, r_rm, r_um);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_interlock_unit.md
Name: pipeline_interlock_unit

Overview:
- Producer-side complement to the EX/MEM/WB forwarding logic of the LEGv8 5-stage pipeline.
- Covers the hazards forwarding cannot resolve:
  - load-use: one-cycle stall plus ID/EX bubble;
  - taken branch resolved in MEM: flush IF/ID, ID/EX and EX/MEM;
  - multi-cycle data memory: whole-pipeline freeze with timeout.
- Keeps saturating stall and flush performance counters.
- Sits beside the register file and drives the PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

Parameters:
- MAX_MEM_WAIT, 64: consecutive DMEM_Busy cycles that trigger Timeout.
- CNT_WIDTH, 16: width of the Stall_Count and Flush_Count counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- IDEX_MemRead  in  1  instruction in EX is a load (LDUR)
- IDEX_RegisterRd  in  5  destination of the instruction in EX
- IFID_RegisterRn  in  5  first source of the instruction in ID
- IFID_RegisterRm  in  5  second source (Rm, or Rt for STUR/CBZ) of the instruction in ID
- IFID_UsesRm  in  1  ID instruction actually reads IFID_RegisterRm
- MEM_BranchTaken  in  1  branch resolved taken in MEM stage
- DMEM_Busy  in  1  data memory not ready this cycle
- PCWrite  out  1  PC register enable
- IFID_Write  out  1  IF/ID register enable
- IDEX_Bubble  out  1  zero ID/EX control signals
- IFID_Flush  out  1  clear IF/ID
- IDEX_Flush  out  1  clear ID/EX
- EXMEM_Flush  out  1  clear EX/MEM
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- Timeout  out  1  sticky memory-wait timeout
- Stall_Count  out  CNT_WIDTH  load-use stalls since reset
- Flush_Count  out  CNT_WIDTH  branch flushes since reset

Behaviour:
- State: FSM {RUN, MEM_WAIT}, flag pending_flush, wait counter wait_cnt (clog2(MAX_MEM_WAIT+1) bits).
- Control outputs are combinational from state, flags and inputs. Counters and Timeout are registered.
- Reset (reset high at a clock edge): state=RUN, pending_flush=0, wait_cnt=0, Timeout=0, both counters=0.
- Outputs while reset is high: PCWrite=0, IFID_Write=0, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, IDEX_Bubble=0, Pipe_Freeze=0.
- Reset mid-freeze or with a pending flush discards all state.
- Output priority, highest first:
  1. Freeze (DMEM_Busy=1): PCWrite=0, IFID_Write=0, Pipe_Freeze=1, all flushes 0, IDEX_Bubble=0. MEM_BranchTaken sampled now sets pending_flush.
  2. Flush (DMEM_Busy=0 and (MEM_BranchTaken or pending_flush)): PCWrite=1, IFID_Write=1, all three flushes 1, IDEX_Bubble=0. pending_flush clears. Flush_Count increments. Any load-use hazard this cycle is ignored and not counted.
  3. Load-use: IDEX_MemRead=1, IDEX_RegisterRd!=31, and (IDEX_RegisterRd==IFID_RegisterRn, or IFID_UsesRm=1 and IDEX_RegisterRd==IFID_RegisterRm). Outputs: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Stall_Count increments.
  4. Normal: PCWrite=1, IFID_Write=1, all others 0.
- X31 (XZR) as load destination never stalls.
- Stall length: a load-use stall lasts exactly one cycle, because the bubble removes the load from EX.
- FSM transitions:
  - RUN -> MEM_WAIT when DMEM_Busy=1.
  - MEM_WAIT -> RUN on the first cycle DMEM_Busy=0; outputs that cycle follow priorities 2-4.
- wait_cnt: increments each busy cycle, saturating at MAX_MEM_WAIT; clears when DMEM_Busy=0.
- Timeout: set on the edge at which wait_cnt reaches MAX_MEM_WAIT. It stays 1 until reset. Freeze continues while busy.
- Counters saturate at all-ones with no wrap.

Test Plan:
- Load-use on Rn: IDEX_MemRead=1, IDEX_RegisterRd=5, IFID_RegisterRn=5 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Bubble=1 that cycle, normal outputs next cycle, Stall_Count=1.
- Rm and XZR filtering:
  - Rd=7, IFID_RegisterRm=7, IFID_UsesRm=0 -> no stall.
  - Same with IFID_UsesRm=1 -> stall.
  - Rd=31, IFID_RegisterRn=31 -> no stall.
- Branch over hazard: MEM_BranchTaken=1 together with a load-use match -> all three flushes 1, PCWrite=1, IDEX_Bubble=0, Flush_Count=1, Stall_Count=0.
- Busy and branch: DMEM_Busy=1 for 3 cycles with MEM_BranchTaken pulsed in cycle 1 -> Pipe_Freeze=1 and PCWrite=0 for 3 cycles, flushes 0; on the 4th cycle (busy=0) flushes=1 and Flush_Count=1.
- Timeout with MAX_MEM_WAIT=4:
  - DMEM_Busy held 6 cycles -> Timeout rises after the 4th busy edge and stays 1 after busy drops.
  - reset=1 for one cycle -> Timeout=0, counters 0, flush outputs 1 during reset.
- Saturation with CNT_WIDTH=2: five load-use stalls -> Stall_Count holds 3.
